// File: rtl/axi_arbiter_pkg.sv
// Shared definitions for the two-master AXI4 arbiter: FSM state encoding and
// default field widths.
package axi_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_M0,
        WR_M0,
        RD_M1,
        WR_M1
    } arb_state_e;

    localparam int unsigned ID_W_DEF    = 4;
    localparam int unsigned AXI_LEN_W   = 8;
    localparam int unsigned AXI_SIZE_W  = 3;
    localparam int unsigned AXI_BURST_W = 2;
    localparam int unsigned AXI_RESP_W  = 2;

endpackage

// File: rtl/axi_arbiter_rr_pick.sv
// Two-way round-robin grant: a lone requester wins; on a tie the master that
// was not granted last wins.
module arb_rr_pick (
    input  logic req_m0_i,
    input  logic req_m1_i,
    input  logic last_gnt_m1_i,
    output logic gnt_valid_o,
    output logic gnt_m1_o
);

    assign gnt_valid_o = req_m0_i | req_m1_i;
    assign gnt_m1_o    = req_m1_i & (~req_m0_i | ~last_gnt_m1_i);

endmodule

// File: rtl/axi_arbiter.sv
// Arbitrates the instruction-fetch (m0) and load/store (m1) AXI4 masters onto a
// single downstream port; one transaction at a time, payloads pass through.
module axi_arbiter
    import axi_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = ID_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    // m0: instruction fetch
    input  logic                   m0_awvalid_i,
    output logic                   m0_awready_o,
    input  logic [ADDR_W-1:0]      m0_awaddr_i,
    input  logic [ID_W-1:0]        m0_awid_i,
    input  logic [AXI_LEN_W-1:0]   m0_awlen_i,
    input  logic [AXI_SIZE_W-1:0]  m0_awsize_i,
    input  logic [AXI_BURST_W-1:0] m0_awburst_i,
    input  logic                   m0_wvalid_i,
    output logic                   m0_wready_o,
    input  logic [DATA_W-1:0]      m0_wdata_i,
    input  logic [DATA_W/8-1:0]    m0_wstrb_i,
    input  logic                   m0_wlast_i,
    output logic                   m0_bvalid_o,
    input  logic                   m0_bready_i,
    output logic [ID_W-1:0]        m0_bid_o,
    output logic [AXI_RESP_W-1:0]  m0_bresp_o,
    input  logic                   m0_arvalid_i,
    output logic                   m0_arready_o,
    input  logic [ADDR_W-1:0]      m0_araddr_i,
    input  logic [ID_W-1:0]        m0_arid_i,
    input  logic [AXI_LEN_W-1:0]   m0_arlen_i,
    input  logic [AXI_SIZE_W-1:0]  m0_arsize_i,
    input  logic [AXI_BURST_W-1:0] m0_arburst_i,
    output logic                   m0_rvalid_o,
    input  logic                   m0_rready_i,
    output logic [DATA_W-1:0]      m0_rdata_o,
    output logic [ID_W-1:0]        m0_rid_o,
    output logic [AXI_RESP_W-1:0]  m0_rresp_o,
    output logic                   m0_rlast_o,
    // m1: load/store
    input  logic                   m1_awvalid_i,
    output logic                   m1_awready_o,
    input  logic [ADDR_W-1:0]      m1_awaddr_i,
    input  logic [ID_W-1:0]        m1_awid_i,
    input  logic [AXI_LEN_W-1:0]   m1_awlen_i,
    input  logic [AXI_SIZE_W-1:0]  m1_awsize_i,
    input  logic [AXI_BURST_W-1:0] m1_awburst_i,
    input  logic                   m1_wvalid_i,
    output logic                   m1_wready_o,
    input  logic [DATA_W-1:0]      m1_wdata_i,
    input  logic [DATA_W/8-1:0]    m1_wstrb_i,
    input  logic                   m1_wlast_i,
    output logic                   m1_bvalid_o,
    input  logic                   m1_bready_i,
    output logic [ID_W-1:0]        m1_bid_o,
    output logic [AXI_RESP_W-1:0]  m1_bresp_o,
    input  logic                   m1_arvalid_i,
    output logic                   m1_arready_o,
    input  logic [ADDR_W-1:0]      m1_araddr_i,
    input  logic [ID_W-1:0]        m1_arid_i,
    input  logic [AXI_LEN_W-1:0]   m1_arlen_i,
    input  logic [AXI_SIZE_W-1:0]  m1_arsize_i,
    input  logic [AXI_BURST_W-1:0] m1_arburst_i,
    output logic                   m1_rvalid_o,
    input  logic                   m1_rready_i,
    output logic [DATA_W-1:0]      m1_rdata_o,
    output logic [ID_W-1:0]        m1_rid_o,
    output logic [AXI_RESP_W-1:0]  m1_rresp_o,
    output logic                   m1_rlast_o,
    // downstream slave
    output logic                   s_awvalid_o,
    input  logic                   s_awready_i,
    output logic [ADDR_W-1:0]      s_awaddr_o,
    output logic [ID_W-1:0]        s_awid_o,
    output logic [AXI_LEN_W-1:0]   s_awlen_o,
    output logic [AXI_SIZE_W-1:0]  s_awsize_o,
    output logic [AXI_BURST_W-1:0] s_awburst_o,
    output logic                   s_wvalid_o,
    input  logic                   s_wready_i,
    output logic [DATA_W-1:0]      s_wdata_o,
    output logic [DATA_W/8-1:0]    s_wstrb_o,
    output logic                   s_wlast_o,
    input  logic                   s_bvalid_i,
    output logic                   s_bready_o,
    input  logic [ID_W-1:0]        s_bid_i,
    input  logic [AXI_RESP_W-1:0]  s_bresp_i,
    output logic                   s_arvalid_o,
    input  logic                   s_arready_i,
    output logic [ADDR_W-1:0]      s_araddr_o,
    output logic [ID_W-1:0]        s_arid_o,
    output logic [AXI_LEN_W-1:0]   s_arlen_o,
    output logic [AXI_SIZE_W-1:0]  s_arsize_o,
    output logic [AXI_BURST_W-1:0] s_arburst_o,
    input  logic                   s_rvalid_i,
    output logic                   s_rready_o,
    input  logic [DATA_W-1:0]      s_rdata_i,
    input  logic [ID_W-1:0]        s_rid_i,
    input  logic [AXI_RESP_W-1:0]  s_rresp_i,
    input  logic                   s_rlast_i
);

    arb_state_e state_q;
    logic       last_gnt_q;   // 1 = m1 was granted last
    logic       gnt_valid;
    logic       gnt_m1;
    logic       rd_m0, wr_m0, rd_m1, wr_m1, sel_m1;

    arb_rr_pick u_pick (
        .req_m0_i      (m0_arvalid_i | m0_awvalid_i),
        .req_m1_i      (m1_arvalid_i | m1_awvalid_i),
        .last_gnt_m1_i (last_gnt_q),
        .gnt_valid_o   (gnt_valid),
        .gnt_m1_o      (gnt_m1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        last_gnt_q <= gnt_m1;
                        if (gnt_m1) state_q <= m1_arvalid_i ? RD_M1 : WR_M1;
                        else        state_q <= m0_arvalid_i ? RD_M0 : WR_M0;
                    end
                end
                RD_M0, RD_M1: if (s_rvalid_i && s_rready_o && s_rlast_i) state_q <= IDLE;
                WR_M0, WR_M1: if (s_bvalid_i && s_bready_o) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_m0  = (state_q == RD_M0);
    assign wr_m0  = (state_q == WR_M0);
    assign rd_m1  = (state_q == RD_M1);
    assign wr_m1  = (state_q == WR_M1);
    assign sel_m1 = rd_m1 | wr_m1;

    // Payload muxes are free-running; only the handshake signals are gated by state.
    assign s_awaddr_o  = sel_m1 ? m1_awaddr_i  : m0_awaddr_i;
    assign s_awid_o    = sel_m1 ? m1_awid_i    : m0_awid_i;
    assign s_awlen_o   = sel_m1 ? m1_awlen_i   : m0_awlen_i;
    assign s_awsize_o  = sel_m1 ? m1_awsize_i  : m0_awsize_i;
    assign s_awburst_o = sel_m1 ? m1_awburst_i : m0_awburst_i;
    assign s_wdata_o   = sel_m1 ? m1_wdata_i   : m0_wdata_i;
    assign s_wstrb_o   = sel_m1 ? m1_wstrb_i   : m0_wstrb_i;
    assign s_wlast_o   = sel_m1 ? m1_wlast_i   : m0_wlast_i;
    assign s_araddr_o  = sel_m1 ? m1_araddr_i  : m0_araddr_i;
    assign s_arid_o    = sel_m1 ? m1_arid_i    : m0_arid_i;
    assign s_arlen_o   = sel_m1 ? m1_arlen_i   : m0_arlen_i;
    assign s_arsize_o  = sel_m1 ? m1_arsize_i  : m0_arsize_i;
    assign s_arburst_o = sel_m1 ? m1_arburst_i : m0_arburst_i;

    assign s_arvalid_o = (rd_m0 & m0_arvalid_i) | (rd_m1 & m1_arvalid_i);
    assign s_rready_o  = (rd_m0 & m0_rready_i)  | (rd_m1 & m1_rready_i);
    assign s_awvalid_o = (wr_m0 & m0_awvalid_i) | (wr_m1 & m1_awvalid_i);
    assign s_wvalid_o  = (wr_m0 & m0_wvalid_i)  | (wr_m1 & m1_wvalid_i);
    assign s_bready_o  = (wr_m0 & m0_bready_i)  | (wr_m1 & m1_bready_i);

    assign m0_arready_o = rd_m0 & s_arready_i;
    assign m0_rvalid_o  = rd_m0 & s_rvalid_i;
    assign m0_awready_o = wr_m0 & s_awready_i;
    assign m0_wready_o  = wr_m0 & s_wready_i;
    assign m0_bvalid_o  = wr_m0 & s_bvalid_i;
    assign m1_arready_o = rd_m1 & s_arready_i;
    assign m1_rvalid_o  = rd_m1 & s_rvalid_i;
    assign m1_awready_o = wr_m1 & s_awready_i;
    assign m1_wready_o  = wr_m1 & s_wready_i;
    assign m1_bvalid_o  = wr_m1 & s_bvalid_i;

    assign m0_rdata_o = s_rdata_i;
    assign m0_rid_o   = s_rid_i;
    assign m0_rresp_o = s_rresp_i;
    assign m0_rlast_o = s_rlast_i;
    assign m0_bid_o   = s_bid_i;
    assign m0_bresp_o = s_bresp_i;
    assign m1_rdata_o = s_rdata_i;
    assign m1_rid_o   = s_rid_i;
    assign m1_rresp_o = s_rresp_i;
    assign m1_rlast_o = s_rlast_i;
    assign m1_bid_o   = s_bid_i;
    assign m1_bresp_o = s_bresp_i;

endmodule

// File: tb/tb_axi_arbiter.sv
// Bench for axi_arbiter: bench-driven masters and slave, with a round-robin
// grant model checking each arbitration and every forwarded beat.
module tb_axi_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // master-side stimulus, index = master number
    logic [1:0]       av, awv, wv, wl, bready, rready;
    logic [1:0][31:0] addr, wd;
    logic [1:0][3:0]  id, ws;
    logic [1:0][7:0]  len;
    logic [1:0][2:0]  sz;
    logic [1:0][1:0]  bu;
    // master-side observations
    wire  [1:0]       o_awready, o_wready, o_bvalid, o_arready, o_rvalid, o_rlast;
    wire  [1:0][3:0]  o_bid, o_rid;
    wire  [1:0][1:0]  o_bresp, o_rresp;
    wire  [1:0][31:0] o_rdata;
    // slave side
    wire         s_awvalid, s_wvalid, s_wlast, s_bready, s_arvalid, s_rready;
    wire  [31:0] s_awaddr, s_wdata, s_araddr;
    wire  [3:0]  s_awid, s_wstrb, s_arid;
    wire  [7:0]  s_awlen, s_arlen;
    wire  [2:0]  s_awsize, s_arsize;
    wire  [1:0]  s_awburst, s_arburst;
    logic        s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_rlast;
    logic [3:0]  s_bid, s_rid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int model_last;   // master granted last, per the round-robin rule
    int last_obs;

    axi_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
        .clk(clk), .rst(rst),
        .m0_awvalid_i(awv[0]), .m0_awready_o(o_awready[0]), .m0_awaddr_i(addr[0]), .m0_awid_i(id[0]),
        .m0_awlen_i(len[0]), .m0_awsize_i(sz[0]), .m0_awburst_i(bu[0]),
        .m0_wvalid_i(wv[0]), .m0_wready_o(o_wready[0]), .m0_wdata_i(wd[0]), .m0_wstrb_i(ws[0]), .m0_wlast_i(wl[0]),
        .m0_bvalid_o(o_bvalid[0]), .m0_bready_i(bready[0]), .m0_bid_o(o_bid[0]), .m0_bresp_o(o_bresp[0]),
        .m0_arvalid_i(av[0]), .m0_arready_o(o_arready[0]), .m0_araddr_i(addr[0]), .m0_arid_i(id[0]),
        .m0_arlen_i(len[0]), .m0_arsize_i(sz[0]), .m0_arburst_i(bu[0]),
        .m0_rvalid_o(o_rvalid[0]), .m0_rready_i(rready[0]), .m0_rdata_o(o_rdata[0]), .m0_rid_o(o_rid[0]),
        .m0_rresp_o(o_rresp[0]), .m0_rlast_o(o_rlast[0]),
        .m1_awvalid_i(awv[1]), .m1_awready_o(o_awready[1]), .m1_awaddr_i(addr[1]), .m1_awid_i(id[1]),
        .m1_awlen_i(len[1]), .m1_awsize_i(sz[1]), .m1_awburst_i(bu[1]),
        .m1_wvalid_i(wv[1]), .m1_wready_o(o_wready[1]), .m1_wdata_i(wd[1]), .m1_wstrb_i(ws[1]), .m1_wlast_i(wl[1]),
        .m1_bvalid_o(o_bvalid[1]), .m1_bready_i(bready[1]), .m1_bid_o(o_bid[1]), .m1_bresp_o(o_bresp[1]),
        .m1_arvalid_i(av[1]), .m1_arready_o(o_arready[1]), .m1_araddr_i(addr[1]), .m1_arid_i(id[1]),
        .m1_arlen_i(len[1]), .m1_arsize_i(sz[1]), .m1_arburst_i(bu[1]),
        .m1_rvalid_o(o_rvalid[1]), .m1_rready_i(rready[1]), .m1_rdata_o(o_rdata[1]), .m1_rid_o(o_rid[1]),
        .m1_rresp_o(o_rresp[1]), .m1_rlast_o(o_rlast[1]),
        .s_awvalid_o(s_awvalid), .s_awready_i(s_awready), .s_awaddr_o(s_awaddr), .s_awid_o(s_awid),
        .s_awlen_o(s_awlen), .s_awsize_o(s_awsize), .s_awburst_o(s_awburst),
        .s_wvalid_o(s_wvalid), .s_wready_i(s_wready), .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb), .s_wlast_o(s_wlast),
        .s_bvalid_i(s_bvalid), .s_bready_o(s_bready), .s_bid_i(s_bid), .s_bresp_i(s_bresp),
        .s_arvalid_o(s_arvalid), .s_arready_i(s_arready), .s_araddr_o(s_araddr), .s_arid_o(s_arid),
        .s_arlen_o(s_arlen), .s_arsize_o(s_arsize), .s_arburst_o(s_arburst),
        .s_rvalid_i(s_rvalid), .s_rready_o(s_rready), .s_rdata_i(s_rdata), .s_rid_i(s_rid),
        .s_rresp_i(s_rresp), .s_rlast_i(s_rlast)
    );

    task automatic clear_all();
        av = '0; awv = '0; wv = '0; wl = '0; bready = '0; rready = '0;
        addr = '0; wd = '0; id = '0; ws = '0; len = '0; sz = '0; bu = '0;
        s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1;
        s_bvalid = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
        s_bid = '0; s_rid = '0; s_bresp = '0; s_rresp = '0; s_rdata = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clear_all();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_last = 1;
    endtask

    task automatic new_req(input int m, input bit rd, input bit both);
        logic [31:0] a;
        a = $urandom;
        a[0] = m[0];                  // keeps the two masters' addresses distinct
        addr[m] = a;
        id[m]   = 4'($urandom_range(0, 15));
        len[m]  = 8'($urandom_range(0, 3));
        sz[m]   = 3'($urandom_range(0, 7));
        bu[m]   = 2'($urandom_range(0, 3));
        if (rd || both) av[m] = 1'b1;
        if (!rd || both) awv[m] = 1'b1;
    endtask

    function automatic int model_pick();
        logic r0, r1;
        r0 = av[0] | awv[0];
        r1 = av[1] | awv[1];
        if (r0 && r1) return (model_last == 0) ? 1 : 0;
        return r1 ? 1 : 0;
    endfunction

    // Called in the IDLE cycle with requests already driven; ends after the address handshake.
    task automatic arbitrate(output int w, output bit rd);
        int   l;
        logic bad;
        w  = model_pick();
        rd = av[w];
        l  = 1 - w;
        @(negedge clk);
        n_tests++;
        if ({s_arvalid, s_awvalid, s_wvalid, o_arready, o_awready, o_wready} !== '0) begin
            n_fail++;
            $display("FAIL idle_quiet: got arv=%b awv=%b wv=%b arrdy=%b awrdy=%b wrdy=%b, required all 0",
                     s_arvalid, s_awvalid, s_wvalid, o_arready, o_awready, o_wready);
        end
        @(posedge clk); #1;
        model_last = w;
        @(negedge clk);
        last_obs = (o_arready[1] | o_awready[1]) ? 1 : 0;
        n_tests++;
        if (last_obs != w || (o_arready[w] | o_awready[w]) !== 1'b1) begin
            n_fail++;
            $display("FAIL grant: got m%0d (arrdy=%b awrdy=%b), required m%0d", last_obs, o_arready, o_awready, w);
        end
        n_tests++;
        if (s_arvalid !== rd || s_awvalid !== !rd) begin
            n_fail++;
            $display("FAIL direction: got arvalid=%b awvalid=%b, required read=%0d", s_arvalid, s_awvalid, rd);
        end
        if (rd) bad = (s_araddr !== addr[w]) || (s_arid !== id[w]) || (s_arlen !== len[w]) ||
                      (s_arsize !== sz[w]) || (s_arburst !== bu[w]);
        else    bad = (s_awaddr !== addr[w]) || (s_awid !== id[w]) || (s_awlen !== len[w]) ||
                      (s_awsize !== sz[w]) || (s_awburst !== bu[w]);
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL addr_payload: got ar=%h aw=%h id=%h/%h, required addr=%h id=%h",
                     s_araddr, s_awaddr, s_arid, s_awid, addr[w], id[w]);
        end
        n_tests++;
        if ((o_arready[l] | o_awready[l] | o_wready[l]) !== 1'b0) begin
            n_fail++;
            $display("FAIL loser_ready: got ar=%b aw=%b w=%b on m%0d, required 0", o_arready[l], o_awready[l], o_wready[l], l);
        end
        @(posedge clk); #1;
        if (rd) av[w] = 1'b0; else awv[w] = 1'b0;
    endtask

    // Data/response phase of the granted transaction; returns in the following IDLE cycle.
    task automatic serve(input int w, input bit rd, input int lat, input logic [1:0] resp, input logic [31:0] seed);
        int          l;
        logic [1:0]  ev;
        logic [31:0] d;
        l  = 1 - w;
        ev = (w == 1) ? 2'b10 : 2'b01;
        if (rd) begin
            rready = 2'b11;
            repeat (lat) begin
                @(negedge clk);
                n_tests++;
                if (o_rvalid !== 2'b00 || o_awready[l] !== 1'b0 || o_arready[l] !== 1'b0 || s_awvalid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rd_wait: got rvalid=%b loser awrdy=%b arrdy=%b s_awvalid=%b, required 0",
                             o_rvalid, o_awready[l], o_arready[l], s_awvalid);
                end
                @(posedge clk); #1;
            end
            for (int b = 0; b <= int'(len[w]); b++) begin
                d = seed ^ (32'(b) * 32'h0101_0101);
                s_rvalid = 1'b1; s_rdata = d; s_rresp = resp; s_rid = id[w];
                s_rlast = (b == int'(len[w]));
                @(negedge clk);
                n_tests++;
                if (o_rvalid !== ev || o_rdata[w] !== d || o_rresp[w] !== resp || o_rid[w] !== id[w] ||
                    o_rlast[w] !== s_rlast || s_rready !== 1'b1 || o_awready[l] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rd_beat%0d: got rvalid=%b data=%h resp=%0d id=%h last=%b rready=%b, required rvalid=%b data=%h resp=%0d id=%h",
                             b, o_rvalid, o_rdata[w], o_rresp[w], o_rid[w], o_rlast[w], s_rready, ev, d, resp, id[w]);
                end
                @(posedge clk); #1;
            end
            s_rvalid = 1'b0; s_rlast = 1'b0; rready = '0;
        end else begin
            for (int b = 0; b <= int'(len[w]); b++) begin
                d = seed ^ (32'(b) * 32'h0101_0101);
                wv[w] = 1'b1; wd[w] = d; ws[w] = d[3:0]; wl[w] = (b == int'(len[w]));
                @(negedge clk);
                n_tests++;
                if (s_wvalid !== 1'b1 || s_wdata !== d || s_wstrb !== d[3:0] || s_wlast !== wl[w] ||
                    o_wready !== ev || o_arready[l] !== 1'b0 || o_awready[l] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wr_beat%0d: got wvalid=%b data=%h strb=%h last=%b wready=%b, required 1 %h %h %b %b",
                             b, s_wvalid, s_wdata, s_wstrb, s_wlast, o_wready, d, d[3:0], wl[w], ev);
                end
                @(posedge clk); #1;
            end
            wv[w] = 1'b0; wl[w] = 1'b0; bready = 2'b11;
            repeat (lat) begin
                @(negedge clk);
                n_tests++;
                if (o_bvalid !== 2'b00 || s_wvalid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wr_wait: got bvalid=%b wvalid=%b, required 0", o_bvalid, s_wvalid);
                end
                @(posedge clk); #1;
            end
            s_bvalid = 1'b1; s_bresp = resp; s_bid = id[w];
            @(negedge clk);
            n_tests++;
            if (o_bvalid !== ev || o_bresp[w] !== resp || o_bid[w] !== id[w] || s_bready !== 1'b1) begin
                n_fail++;
                $display("FAIL bresp: got bvalid=%b resp=%0d id=%h bready=%b, required bvalid=%b resp=%0d id=%h",
                         o_bvalid, o_bresp[w], o_bid[w], s_bready, ev, resp, id[w]);
            end
            @(posedge clk); #1;
            s_bvalid = 1'b0; bready = '0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_all();
        av = 2'b11; awv = 2'b11; wv = 2'b11; rready = 2'b11; bready = 2'b11;
        s_rvalid = 1'b1; s_bvalid = 1'b1;
        @(posedge clk); #1;
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if ({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready,
                 o_arready, o_awready, o_wready, o_rvalid, o_bvalid} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: got s=%b%b%b%b%b ar=%b aw=%b w=%b r=%b b=%b, required all 0",
                         s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready,
                         o_arready, o_awready, o_wready, o_rvalid, o_bvalid);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_single_read();
        int w; bit rd;
        apply_reset();
        new_req(0, 1'b1, 1'b0);
        addr[0] = 32'h8000_0000; len[0] = 8'd0;
        arbitrate(w, rd);
        serve(w, rd, 3, 2'd0, 32'h0000_0413);
        new_req(0, 1'b1, 1'b0);   // IDLE must be visible the cycle after rlast
        arbitrate(w, rd);
        serve(w, rd, 1, 2'd0, $urandom);
    endtask

    task automatic test_conflict();
        int w; bit rd;
        apply_reset();
        new_req(0, 1'b1, 1'b0);
        new_req(1, 1'b0, 1'b0);
        arbitrate(w, rd);
        serve(w, rd, 2, 2'd0, $urandom);
        arbitrate(w, rd);
        serve(w, rd, 1, 2'd0, $urandom);
    endtask

    task automatic test_write();
        int w; bit rd;
        apply_reset();
        new_req(1, 1'b0, 1'b0);
        addr[1] = 32'ha000_03f8; len[1] = 8'd0;
        arbitrate(w, rd);
        serve(w, rd, 2, 2'd0, 32'h0000_0041);
    endtask

    task automatic test_alternate();
        int w; bit rd;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            for (int m = 0; m < 2; m++)
                if (!(av[m] | awv[m])) new_req(m, 1'($urandom_range(0, 1)), 1'b0);
            arbitrate(w, rd);
            n_tests++;
            if (last_obs != (i % 2)) begin
                n_fail++;
                $display("FAIL alt_order: transaction %0d got m%0d, required m%0d", i, last_obs, i % 2);
            end
            serve(w, rd, $urandom_range(0, 2), 2'($urandom_range(0, 3)), $urandom);
        end
    endtask

    task automatic test_burst();
        int w; bit rd;
        apply_reset();
        new_req(1, 1'b1, 1'b0);
        len[1] = 8'd3;
        arbitrate(w, rd);
        serve(w, rd, 1, 2'd2, $urandom);
        new_req(1, 1'b0, 1'b0);
        arbitrate(w, rd);
        serve(w, rd, 0, 2'd3, $urandom);
    endtask

    task automatic test_reset_mid();
        int w; bit rd;
        apply_reset();
        new_req(0, 1'b1, 1'b0);
        arbitrate(w, rd);
        rready = 2'b11;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_all();
        model_last = 1;
        s_rvalid = 1'b1; s_bvalid = 1'b1; rready = 2'b11;
        @(negedge clk);
        n_tests++;
        if ({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready,
             o_arready, o_awready, o_wready, o_rvalid, o_bvalid} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got r=%b rready=%b arv=%b, required all 0", o_rvalid, s_rready, s_arvalid);
        end
        @(posedge clk); #1;
        s_rvalid = 1'b0; s_bvalid = 1'b0; rready = '0;
        new_req(1, 1'b1, 1'b0);
        arbitrate(w, rd);
        serve(w, rd, 1, 2'd0, $urandom);
    endtask

    task automatic test_random();
        int w; bit rd;
        apply_reset();
        for (int it = 0; it < 24; it++) begin
            for (int m = 0; m < 2; m++)
                if (!(av[m] | awv[m]) && $urandom_range(0, 1) == 1)
                    new_req(m, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
            if ((av | awv) == 2'b00)
                new_req(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            arbitrate(w, rd);
            serve(w, rd, $urandom_range(0, 3), 2'($urandom_range(0, 3)), $urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_conflict();
        test_write();
        test_alternate();
        test_burst();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
